rgb_rx_monitor: RTL and testbench
=================================

// Module: rgb_rx_monitor
// PURPOSE
//  Receive side of the parallel RGB LCD interface (hs/vs/de + 24-bit data).
//  - Recovers the pixel x/y position of each incoming pixel.
//  - Measures active and total timing, and declares lock on stable geometry.
//  - Samples one probe pixel per frame.
//  Sits after the LCD pattern generator (loopback) or after an external video source, ahead of the checkers.
// PARAMETERS
//  SYNC_POL     0    hs/vs assert level: 0 = active-low, 1 = active-high
//  CNT_W        12   width of every position/measurement counter; counters saturate at 2^CNT_W-1
//  LOCK_FRAMES  3    consecutive frames with identical h_active and v_active needed for lock (1..15)
// PORTS
//  i_rgb_clk     in   1      pixel clock; all logic on rising edge
//  i_rgb_rst_n   in   1      asynchronous active-low reset
//  i_rgb_hs      in   1      horizontal sync, level per SYNC_POL
//  i_rgb_vs      in   1      vertical sync, level per SYNC_POL
//  i_rgb_de      in   1      data enable, active-high
//  i_rgb_data    in   24     pixel {R,G,B}
//  i_probe_x     in   CNT_W  probe column
//  i_probe_y     in   CNT_W  probe row
//  o_rx_valid    out  1      o_rx_data/x/y valid (delayed DE)
//  o_rx_data     out  24     pixel data, delayed
//  o_rx_x        out  CNT_W  active column of o_rx_data
//  o_rx_y        out  CNT_W  active row of o_rx_data
//  o_h_active    out  CNT_W  DE-high pixels in last complete line
//  o_v_active    out  CNT_W  DE lines in last complete frame
//  o_h_total     out  CNT_W  clocks between last two hs assert edges
//  o_v_total     out  CNT_W  hs assert edges between last two vs assert edges
//  o_probe_rgb   out  24     pixel captured at (i_probe_x, i_probe_y) in last frame
//  o_frame_done  out  1      one-cycle pulse on each vs assert edge
//  o_locked      out  1      geometry stable
// BEHAVIOUR
//  - Reset: all outputs 0; all counters 0; FSM = SEARCH.
//  - Reset is async on assert, sync on release.
//  - Input register:
//    - All inputs are registered once (stage S1).
//    - hs/vs are normalised to active-high using SYNC_POL.
//    - Edges are detected S1 vs S2.
//  - Latency: o_rx_valid/data/x/y lag i_rgb_de/i_rgb_data by exactly 2 clocks.
//  - Position counters:
//    - x: 0 on the first DE pixel of a line; +1 per DE-high pixel.
//    - y: 0 after a vs assert edge; +1 on each DE falling edge.
//    - Both saturate and never wrap.
//  - Line and frame measurements:
//    - o_h_active is updated on the DE falling edge; o_v_active is updated on the vs assert edge.
//    - o_h_total counts clocks between hs assert edges and updates on each edge.
//    - o_v_total counts hs assert edges between vs assert edges and updates on each vs edge.
//    - Counters restart at 1 on the edge that latches them.
//    - Values from a partial first line or frame after reset are never latched; the first edge only arms the counter.
//  - Probe:
//    - Capture happens when S2 is valid and x==i_probe_x and y==i_probe_y.
//    - o_probe_rgb updates on the vs assert edge with the frame's captured value.
//    - The previous value is held if the probe point was not hit.
//  - o_frame_done: 1 cycle, coincident with the o_v_active update.
//  - Lock FSM is evaluated on each vs assert edge:
//    - SEARCH -> TRACK on the first complete frame; that frame's geometry becomes the reference, match count = 1.
//    - TRACK: geometry equal to the reference -> count+1, and LOCKED when count == LOCK_FRAMES.
//    - TRACK: geometry not equal -> new reference, count = 1.
//    - LOCKED: any mismatch -> SEARCH-equivalent restart (o_locked=0, reference=new, count=1) in the same cycle.
//    - o_locked = (state == LOCKED); it changes only on the cycle after the vs edge.
//  - Boundary cases:
//    - DE high across a vs edge: the vs edge wins; y=0, and the line in progress is not counted in o_v_active.
//    - hs and vs asserting on the same clock: both edges are processed; o_v_total includes that hs edge in the new frame.
//    - DE never high in a frame: o_v_active=0, o_h_active holds.
//    - Reset mid-frame: everything returns to its reset value; the next partial frame is discarded.
// CONFIGURATION
//  RGB_RX_CHECKSUM_EN
//  - Defined: adds port o_frame_sum (out, 24).
//    - Per valid S2 pixel: sum <= {sum[22:0],sum[23]} ^ data.
//    - The sum clears at the vs edge, and o_frame_sum latches the pre-clear value on the same edge.
//    - o_frame_sum is 0 at reset.
//  - Undefined: the port and logic are absent; all other behaviour is identical.
// TESTING
//  1. 800x480 active, h_total=1056, v_total=525, 4 frames.
//     -> h_active=800, v_active=480, h_total=1056, v_total=525.
//     -> o_locked=1 the cycle after the 3rd complete vs edge (default LOCK_FRAMES=3).
//  2. Locked, then one frame with 799-pixel lines -> o_locked=0 after that vs edge, and lock regained after 3 more 800-wide frames.
//  3. Probe (0,0), (799,479), (400,240) with a ramp pattern -> o_probe_rgb equals the injected pixel; probe (900,0) -> value held.
//  4. Pixel 0xA5A5A5 on DE rise -> o_rx_data=0xA5A5A5 with o_rx_valid=1, x=0, exactly 2 clocks later.
//  5. SYNC_POL=1 and SYNC_POL=0 benches with identical timing -> identical measurements.
//     Reset asserted mid-line -> all outputs 0 immediately; first frame after release not latched.
//  6. RGB_RX_CHECKSUM_EN, 4x2 frame of all 0x000001 -> o_frame_sum matches the reference model.
//     Repeat the same frame -> identical sum.

Source files
------------

// File: rtl/rgb_rx_monitor.sv
// rgb_rx_monitor
// Receive-side monitor for a parallel RGB LCD interface (hs/vs/de + 24-bit data).
// Recovers per-pixel x/y, measures active/total line and frame geometry,
// declares lock once the geometry is stable, and samples one probe pixel per frame.
//
// Ports
//   i_rgb_clk, i_rgb_rst_n          pixel clock, async active-low reset
//   i_rgb_hs/vs/de/data             video input (hs/vs polarity set by SYNC_POL)
//   i_probe_x/y                     probe coordinate
//   o_rx_valid/data/x/y             input pixel delayed by 2 clocks, with its position
//   o_h_active/o_v_active           active pixels per line / active lines per frame
//   o_h_total/o_v_total             clocks per line / lines per frame
//   o_probe_rgb                     pixel captured at the probe coordinate last frame
//   o_frame_done                    one-cycle pulse per vs assert edge
//   o_locked                        geometry stable for LOCK_FRAMES frames
//   o_frame_sum                     rotate-xor checksum of the last frame
//                                   (only when RGB_RX_CHECKSUM_EN is defined)
//
// Lock FSM
//   state      | meaning
//   ST_SEARCH  | no reference geometry yet
//   ST_TRACK   | reference held, counting matching frames
//   ST_LOCKED  | LOCK_FRAMES consecutive matching frames seen
module rgb_rx_monitor #(
    parameter int SYNC_POL    = 0,
    parameter int CNT_W       = 12,
    parameter int LOCK_FRAMES = 3
) (
    input  logic             i_rgb_clk,
    input  logic             i_rgb_rst_n,
    input  logic             i_rgb_hs,
    input  logic             i_rgb_vs,
    input  logic             i_rgb_de,
    input  logic [23:0]      i_rgb_data,
    input  logic [CNT_W-1:0] i_probe_x,
    input  logic [CNT_W-1:0] i_probe_y,
    output logic             o_rx_valid,
    output logic [23:0]      o_rx_data,
    output logic [CNT_W-1:0] o_rx_x,
    output logic [CNT_W-1:0] o_rx_y,
    output logic [CNT_W-1:0] o_h_active,
    output logic [CNT_W-1:0] o_v_active,
    output logic [CNT_W-1:0] o_h_total,
    output logic [CNT_W-1:0] o_v_total,
    output logic [23:0]      o_probe_rgb,
    output logic             o_frame_done,
`ifdef RGB_RX_CHECKSUM_EN
    output logic [23:0]      o_frame_sum,
`endif
    output logic             o_locked
);

    typedef enum logic [1:0] {ST_SEARCH, ST_TRACK, ST_LOCKED} lock_state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]       LOCK_N  = 4'(LOCK_FRAMES);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    logic             hs_s1_q, hs_s1_d, vs_s1_q, vs_s1_d, de_s1_q, de_s1_d;
    logic [23:0]      data_s1_q, data_s1_d;
    logic             hs_s2_q, hs_s2_d, vs_s2_q, vs_s2_d;
    logic             rx_valid_q, rx_valid_d;
    logic [23:0]      rx_data_q, rx_data_d;
    logic [CNT_W-1:0] rx_x_q, rx_x_d, rx_y_q, rx_y_d, row_q, row_d;
    logic             line_act_q, line_act_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d, h_cnt_q, h_cnt_d, v_tot_cnt_q, v_tot_cnt_d;
    logic             h_act_armed_q, h_act_armed_d, h_tot_armed_q, h_tot_armed_d;
    logic             v_armed_q, v_armed_d;
    logic [CNT_W-1:0] h_active_q, h_active_d, v_active_q, v_active_d;
    logic [CNT_W-1:0] h_total_q, h_total_d, v_total_q, v_total_d;
    logic [23:0]      probe_cap_q, probe_cap_d, probe_rgb_q, probe_rgb_d;
    logic             probe_hit_q, probe_hit_d, frame_done_q, frame_done_d;
    lock_state_t      state_q, state_d;
    logic [CNT_W-1:0] ref_h_q, ref_h_d, ref_v_q, ref_v_d;
    logic [3:0]       match_q, match_d;
`ifdef RGB_RX_CHECKSUM_EN
    logic [23:0]      sum_q, sum_d, frame_sum_q, frame_sum_d;
`endif

    logic hs_rise, vs_rise, de_rise, de_fall, line_end, hit_now, frame_eval, geo_match;

    assign hs_rise  = hs_s1_q & ~hs_s2_q;
    assign vs_rise  = vs_s1_q & ~vs_s2_q;
    // rx_valid_q is the S2 copy of DE
    assign de_rise  = de_s1_q & ~rx_valid_q;
    assign de_fall  = ~de_s1_q & rx_valid_q;
    // a line cut by a vs edge is not counted as a frame line
    assign line_end = de_fall & line_act_q & ~vs_rise;
    assign hit_now  = rx_valid_q && (rx_x_q == i_probe_x) && (rx_y_q == i_probe_y);

    always_comb begin
        hs_s1_d       = (SYNC_POL != 0) ? i_rgb_hs : ~i_rgb_hs;
        vs_s1_d       = (SYNC_POL != 0) ? i_rgb_vs : ~i_rgb_vs;
        de_s1_d       = i_rgb_de;
        data_s1_d     = i_rgb_data;
        hs_s2_d       = hs_s1_q;
        vs_s2_d       = vs_s1_q;
        rx_valid_d    = de_s1_q;
        rx_data_d     = data_s1_q;
        rx_x_d        = rx_x_q;
        rx_y_d        = rx_y_q;
        row_d         = row_q;
        line_act_d    = line_act_q;
        v_cnt_d       = v_cnt_q;
        h_cnt_d       = hs_rise ? CNT_ONE : sat_inc(h_cnt_q);
        v_tot_cnt_d   = v_tot_cnt_q;
        h_act_armed_d = h_act_armed_q;
        h_tot_armed_d = h_tot_armed_q;
        v_armed_d     = v_armed_q;
        h_active_d    = h_active_q;
        v_active_d    = v_active_q;
        h_total_d     = h_total_q;
        v_total_d     = v_total_q;
        probe_cap_d   = probe_cap_q;
        probe_hit_d   = probe_hit_q;
        probe_rgb_d   = probe_rgb_q;
        frame_done_d  = vs_rise;

        if (vs_rise)       row_d = '0;
        else if (line_end) row_d = sat_inc(row_q);

        if (de_s1_q) begin
            rx_x_d = rx_valid_q ? sat_inc(rx_x_q) : '0;
            rx_y_d = row_d;
        end

        if (de_rise)                 line_act_d = 1'b1;
        else if (vs_rise || de_fall) line_act_d = 1'b0;

        if (vs_rise)       v_cnt_d = '0;
        else if (line_end) v_cnt_d = sat_inc(v_cnt_q);

        if (de_fall) begin
            h_act_armed_d = 1'b1;
            if (h_act_armed_q) h_active_d = sat_inc(rx_x_q);
        end

        if (hs_rise) begin
            h_tot_armed_d = 1'b1;
            if (h_tot_armed_q) h_total_d = h_cnt_q;
        end

        // an hs edge on the vs clock belongs to the new frame
        if (vs_rise)      v_tot_cnt_d = hs_rise ? CNT_ONE : '0;
        else if (hs_rise) v_tot_cnt_d = sat_inc(v_tot_cnt_q);

        if (vs_rise) begin
            v_armed_d   = 1'b1;
            probe_hit_d = 1'b0;
            if (v_armed_q) begin
                v_active_d = v_cnt_q;
                v_total_d  = v_tot_cnt_q;
                if (hit_now)          probe_rgb_d = rx_data_q;
                else if (probe_hit_q) probe_rgb_d = probe_cap_q;
            end
        end else if (hit_now) begin
            probe_hit_d = 1'b1;
            probe_cap_d = rx_data_q;
        end
    end

`ifdef RGB_RX_CHECKSUM_EN
    always_comb begin
        sum_d       = sum_q;
        frame_sum_d = frame_sum_q;
        if (vs_rise) begin
            frame_sum_d = sum_q;
            sum_d       = '0;
        end else if (rx_valid_q) begin
            sum_d = {sum_q[22:0], sum_q[23]} ^ rx_data_q;
        end
    end
`endif

    assign frame_eval = vs_rise & v_armed_q;
    assign geo_match  = (h_active_q == ref_h_q) && (v_cnt_q == ref_v_q);

    always_comb begin
        state_d = state_q;
        ref_h_d = ref_h_q;
        ref_v_d = ref_v_q;
        match_d = match_q;
        if (frame_eval) begin
            if (state_q == ST_SEARCH || !geo_match) begin
                ref_h_d = h_active_q;
                ref_v_d = v_cnt_q;
                match_d = 4'd1;
                state_d = (LOCK_N == 4'd1) ? ST_LOCKED : ST_TRACK;
            end else if (state_q == ST_TRACK) begin
                match_d = match_q + 4'd1;
                if (match_q + 4'd1 == LOCK_N) state_d = ST_LOCKED;
            end
        end
    end

    always_ff @(posedge i_rgb_clk or negedge i_rgb_rst_n) begin
        if (!i_rgb_rst_n) begin
            hs_s1_q <= 1'b0; vs_s1_q <= 1'b0; de_s1_q <= 1'b0; data_s1_q <= '0;
            hs_s2_q <= 1'b0; vs_s2_q <= 1'b0;
            rx_valid_q <= 1'b0; rx_data_q <= '0; rx_x_q <= '0; rx_y_q <= '0;
            row_q <= '0; line_act_q <= 1'b0;
            v_cnt_q <= '0; h_cnt_q <= '0; v_tot_cnt_q <= '0;
            h_act_armed_q <= 1'b0; h_tot_armed_q <= 1'b0; v_armed_q <= 1'b0;
            h_active_q <= '0; v_active_q <= '0; h_total_q <= '0; v_total_q <= '0;
            probe_cap_q <= '0; probe_hit_q <= 1'b0; probe_rgb_q <= '0;
            frame_done_q <= 1'b0;
            state_q <= ST_SEARCH; ref_h_q <= '0; ref_v_q <= '0; match_q <= '0;
`ifdef RGB_RX_CHECKSUM_EN
            sum_q <= '0; frame_sum_q <= '0;
`endif
        end else begin
            hs_s1_q <= hs_s1_d; vs_s1_q <= vs_s1_d; de_s1_q <= de_s1_d; data_s1_q <= data_s1_d;
            hs_s2_q <= hs_s2_d; vs_s2_q <= vs_s2_d;
            rx_valid_q <= rx_valid_d; rx_data_q <= rx_data_d; rx_x_q <= rx_x_d; rx_y_q <= rx_y_d;
            row_q <= row_d; line_act_q <= line_act_d;
            v_cnt_q <= v_cnt_d; h_cnt_q <= h_cnt_d; v_tot_cnt_q <= v_tot_cnt_d;
            h_act_armed_q <= h_act_armed_d; h_tot_armed_q <= h_tot_armed_d; v_armed_q <= v_armed_d;
            h_active_q <= h_active_d; v_active_q <= v_active_d;
            h_total_q <= h_total_d; v_total_q <= v_total_d;
            probe_cap_q <= probe_cap_d; probe_hit_q <= probe_hit_d; probe_rgb_q <= probe_rgb_d;
            frame_done_q <= frame_done_d;
            state_q <= state_d; ref_h_q <= ref_h_d; ref_v_q <= ref_v_d; match_q <= match_d;
`ifdef RGB_RX_CHECKSUM_EN
            sum_q <= sum_d; frame_sum_q <= frame_sum_d;
`endif
        end
    end

    assign o_rx_valid   = rx_valid_q;
    assign o_rx_data    = rx_data_q;
    assign o_rx_x       = rx_x_q;
    assign o_rx_y       = rx_y_q;
    assign o_h_active   = h_active_q;
    assign o_v_active   = v_active_q;
    assign o_h_total    = h_total_q;
    assign o_v_total    = v_total_q;
    assign o_probe_rgb  = probe_rgb_q;
    assign o_frame_done = frame_done_q;
    assign o_locked     = (state_q == ST_LOCKED);
`ifdef RGB_RX_CHECKSUM_EN
    assign o_frame_sum  = frame_sum_q;
`endif

endmodule

// File: tb/tb_rgb_rx_monitor.sv
module tb_rgb_rx_monitor;
    localparam int CNT_W = 12;
    localparam int H_TOT = 14;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hs_act = 1'b0, vs_act = 1'b0, de = 1'b0;
    logic [23:0] data = '0;
    logic [CNT_W-1:0] probe_x = '0, probe_y = '0;
    logic hs_n, vs_n;
    logic [7:0] fcnt = 8'd1;
    int total = 0;
    int bad = 0;

    assign hs_n = ~hs_act;
    assign vs_n = ~vs_act;

    always #5 clk = ~clk;

    logic             rx_valid, frame_done, locked;
    logic [23:0]      rx_data, probe_rgb;
    logic [CNT_W-1:0] rx_x, rx_y, h_active, v_active, h_total, v_total;
    logic             rx_valid_p, frame_done_p, locked_p;
    logic [23:0]      rx_data_p, probe_rgb_p;
    logic [CNT_W-1:0] rx_x_p, rx_y_p, h_active_p, v_active_p, h_total_p, v_total_p;
`ifdef RGB_RX_CHECKSUM_EN
    logic [23:0]      frame_sum, frame_sum_p;
`endif

    rgb_rx_monitor #(.SYNC_POL(0), .CNT_W(CNT_W), .LOCK_FRAMES(3)) u_dut (
        .i_rgb_clk(clk), .i_rgb_rst_n(rst_n), .i_rgb_hs(hs_n), .i_rgb_vs(vs_n),
        .i_rgb_de(de), .i_rgb_data(data), .i_probe_x(probe_x), .i_probe_y(probe_y),
        .o_rx_valid(rx_valid), .o_rx_data(rx_data), .o_rx_x(rx_x), .o_rx_y(rx_y),
        .o_h_active(h_active), .o_v_active(v_active), .o_h_total(h_total),
        .o_v_total(v_total), .o_probe_rgb(probe_rgb), .o_frame_done(frame_done),
`ifdef RGB_RX_CHECKSUM_EN
        .o_frame_sum(frame_sum),
`endif
        .o_locked(locked)
    );

    rgb_rx_monitor #(.SYNC_POL(1), .CNT_W(CNT_W), .LOCK_FRAMES(3)) u_dut_pos (
        .i_rgb_clk(clk), .i_rgb_rst_n(rst_n), .i_rgb_hs(hs_act), .i_rgb_vs(vs_act),
        .i_rgb_de(de), .i_rgb_data(data), .i_probe_x(probe_x), .i_probe_y(probe_y),
        .o_rx_valid(rx_valid_p), .o_rx_data(rx_data_p), .o_rx_x(rx_x_p), .o_rx_y(rx_y_p),
        .o_h_active(h_active_p), .o_v_active(v_active_p), .o_h_total(h_total_p),
        .o_v_total(v_total_p), .o_probe_rgb(probe_rgb_p), .o_frame_done(frame_done_p),
`ifdef RGB_RX_CHECKSUM_EN
        .o_frame_sum(frame_sum_p),
`endif
        .o_locked(locked_p)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n = 1'b0; hs_act = 1'b0; vs_act = 1'b0; de = 1'b0; data = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Frame: va active lines, one blank line, two vs lines; vs edge coincides with hs edge.
    // Line: hs for clocks 0..1, DE for clocks 4..4+ha-1, H_TOT clocks.
    task automatic run_frame(input int ha, input int va, input bit cst, input logic [23:0] cval,
                             input bit chk, input logic lb, input logic la);
        int vt;
        vt = va + 3;
        for (int l = 0; l < vt; l++) begin
            for (int c = 0; c < H_TOT; c++) begin
                hs_act = (c < 2);
                vs_act = (l >= va + 1);
                de     = (l < va) && (c >= 4) && (c < 4 + ha);
                data   = !de ? 24'h0 : (cst ? cval : {fcnt, 8'(l), 8'(c - 4)});
                @(posedge clk); #1;
                if (chk && l == va + 1 && c == 0) begin
                    total++;
                    if (locked !== lb || frame_done !== 1'b0) begin
                        bad++;
                        $display("FAIL lock_pre_edge locked=%b done=%b exp locked=%b done=0", locked, frame_done, lb);
                    end
                end
                if (chk && l == va + 1 && c == 1) begin
                    total++;
                    if (locked !== la || frame_done !== 1'b1) begin
                        bad++;
                        $display("FAIL lock_post_edge locked=%b done=%b exp locked=%b done=1", locked, frame_done, la);
                    end
                end
            end
        end
        hs_act = 1'b0; vs_act = 1'b1; de = 1'b0; data = '0;
        fcnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; #1;
        total++;
        if ({rx_valid, rx_data, rx_x, rx_y} !== '0) begin
            bad++; $display("FAIL reset_rx got=%0h exp=0", {rx_valid, rx_data, rx_x, rx_y});
        end
        total++;
        if ({h_active, v_active, h_total, v_total} !== '0) begin
            bad++; $display("FAIL reset_meas got=%0h exp=0", {h_active, v_active, h_total, v_total});
        end
        total++;
        if ({probe_rgb, frame_done, locked} !== '0) begin
            bad++; $display("FAIL reset_misc got=%0h exp=0", {probe_rgb, frame_done, locked});
        end
        total++;
        if ({rx_valid_p, rx_data_p, rx_x_p, rx_y_p, h_active_p, v_active_p, h_total_p, v_total_p,
             probe_rgb_p, frame_done_p, locked_p} !== '0) begin
            bad++; $display("FAIL reset_pos_dut outputs not zero");
        end
`ifdef RGB_RX_CHECKSUM_EN
        total++;
        if ({frame_sum, frame_sum_p} !== '0) begin
            bad++; $display("FAIL reset_sum got=%0h exp=0", frame_sum);
        end
`endif
        do_reset();
    endtask

    task automatic test_latency();
        do_reset();
        de = 1'b1; data = 24'hA5A5A5;
        @(posedge clk); #1;
        total++;
        if (rx_valid !== 1'b0) begin
            bad++; $display("FAIL lat_one_clk valid=%b exp=0", rx_valid);
        end
        data = 24'h123456;
        @(posedge clk); #1;
        total++;
        if (rx_valid !== 1'b1 || rx_data !== 24'hA5A5A5 || rx_x !== 12'd0 || rx_y !== 12'd0) begin
            bad++; $display("FAIL lat_first valid=%b data=%h x=%0d y=%0d exp 1 a5a5a5 0 0", rx_valid, rx_data, rx_x, rx_y);
        end
        de = 1'b0; data = '0;
        @(posedge clk); #1;
        total++;
        if (rx_valid !== 1'b1 || rx_data !== 24'h123456 || rx_x !== 12'd1) begin
            bad++; $display("FAIL lat_second valid=%b data=%h x=%0d exp 1 123456 1", rx_valid, rx_data, rx_x);
        end
        @(posedge clk); #1;
        total++;
        if (rx_valid !== 1'b0) begin
            bad++; $display("FAIL lat_end valid=%b exp=0", rx_valid);
        end
    endtask

    task automatic test_sync_lock();
        do_reset();
        run_frame(8, 5, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        run_frame(8, 5, 1'b0, 24'h0, 1'b1, 1'b0, 1'b0);
        run_frame(8, 5, 1'b0, 24'h0, 1'b1, 1'b0, 1'b0);
        run_frame(8, 5, 1'b0, 24'h0, 1'b1, 1'b0, 1'b1);
        total++;
        if (h_active !== 12'd8 || v_active !== 12'd5) begin
            bad++; $display("FAIL geo_active h=%0d v=%0d exp 8 5", h_active, v_active);
        end
        total++;
        if (h_total !== 12'd14 || v_total !== 12'd8) begin
            bad++; $display("FAIL geo_total h=%0d v=%0d exp 14 8", h_total, v_total);
        end
        total++;
        if (h_active_p !== 12'd8 || v_active_p !== 12'd5 || h_total_p !== 12'd14 ||
            v_total_p !== 12'd8 || locked_p !== 1'b1) begin
            bad++; $display("FAIL pos_pol h=%0d v=%0d ht=%0d vt=%0d lk=%b exp 8 5 14 8 1",
                            h_active_p, v_active_p, h_total_p, v_total_p, locked_p);
        end
    endtask

    task automatic test_relock();
        run_frame(7, 5, 1'b0, 24'h0, 1'b1, 1'b1, 1'b0);
        total++;
        if (h_active !== 12'd7) begin
            bad++; $display("FAIL short_line h_active=%0d exp 7", h_active);
        end
        run_frame(8, 5, 1'b0, 24'h0, 1'b1, 1'b0, 1'b0);
        run_frame(8, 5, 1'b0, 24'h0, 1'b1, 1'b0, 1'b0);
        run_frame(8, 5, 1'b0, 24'h0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_probe();
        logic [23:0] exp_v;
        probe_x = 12'd0; probe_y = 12'd0; exp_v = {fcnt, 8'd0, 8'd0};
        run_frame(8, 5, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        total++;
        if (probe_rgb !== exp_v) begin
            bad++; $display("FAIL probe_0_0 got=%h exp=%h", probe_rgb, exp_v);
        end
        probe_x = 12'd7; probe_y = 12'd4; exp_v = {fcnt, 8'd4, 8'd7};
        run_frame(8, 5, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        total++;
        if (probe_rgb !== exp_v) begin
            bad++; $display("FAIL probe_corner got=%h exp=%h", probe_rgb, exp_v);
        end
        probe_x = 12'd3; probe_y = 12'd2; exp_v = {fcnt, 8'd2, 8'd3};
        run_frame(8, 5, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        total++;
        if (probe_rgb !== exp_v) begin
            bad++; $display("FAIL probe_mid got=%h exp=%h", probe_rgb, exp_v);
        end
        probe_x = 12'd20; probe_y = 12'd0;
        run_frame(8, 5, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        total++;
        if (probe_rgb !== exp_v) begin
            bad++; $display("FAIL probe_miss_hold got=%h exp=%h", probe_rgb, exp_v);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        probe_x = 12'd0; probe_y = 12'd0;
        run_frame(8, 5, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        run_frame(8, 5, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        total++;
        if (v_active !== 12'd5) begin
            bad++; $display("FAIL pre_reset v_active=%0d exp 5", v_active);
        end
        vs_act = 1'b0; hs_act = 1'b0; de = 1'b1; data = 24'h777777;
        repeat (3) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0; #1;
        total++;
        if ({rx_valid, h_active, v_active, h_total, v_total, probe_rgb, locked} !== '0) begin
            bad++; $display("FAIL mid_reset outputs=%0h exp=0",
                            {rx_valid, h_active, v_active, h_total, v_total, probe_rgb, locked});
        end
        de = 1'b0; data = '0;
        @(posedge clk); #1 rst_n = 1'b1;
        run_frame(8, 5, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        total++;
        if (v_active !== 12'd0 || v_total !== 12'd0) begin
            bad++; $display("FAIL partial_discard v_active=%0d v_total=%0d exp 0 0", v_active, v_total);
        end
        run_frame(8, 5, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        total++;
        if (v_active !== 12'd5 || v_total !== 12'd8) begin
            bad++; $display("FAIL after_reset v_active=%0d v_total=%0d exp 5 8", v_active, v_total);
        end
    endtask

`ifdef RGB_RX_CHECKSUM_EN
    task automatic test_checksum();
        logic [23:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) s = {s[22:0], s[23]} ^ 24'h000001;
        do_reset();
        run_frame(4, 2, 1'b1, 24'h000001, 1'b0, 1'b0, 1'b0);
        total++;
        if (frame_sum !== s) begin
            bad++; $display("FAIL checksum_first got=%h exp=%h", frame_sum, s);
        end
        run_frame(4, 2, 1'b1, 24'h000001, 1'b0, 1'b0, 1'b0);
        total++;
        if (frame_sum !== s) begin
            bad++; $display("FAIL checksum_repeat got=%h exp=%h", frame_sum, s);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_sync_lock();
        test_relock();
        test_probe();
        test_mid_reset();
`ifdef RGB_RX_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
